reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb.sv | 75 +++++++
 tb/tb_reg_file_sb.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with a per-register pending scoreboard, optional write bypass and hardwired zero register.
module reg_file_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] WriteReg,
   input  logic [DATA_W-1:0] WriteData,
   input  logic [ADDR_W-1:0] ReadReg1,
   input  logic [ADDR_W-1:0] ReadReg2,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2,
   input  logic              Reserve,
   input  logic [ADDR_W-1:0] ReserveReg,
   output logic              Busy1,
   output logic              Busy2,
   output logic              ResvConflict,
   output logic [ADDR_W:0]   PendCount
);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  pend;
   logic [DEPTH-1:0]  pend_nx;
   logic [ADDR_W:0]   cnt_nx;
   logic              wr_ok;
   logic              rsv_ok;
   logic              byp1;
   logic              byp2;
   logic              z1;
   logic              z2;

   // Address 0 is invisible to writes and reservations when hardwired to zero.
   assign wr_ok  = RegWrite && !(ZERO_REG != 0 && WriteReg == '0);
   assign rsv_ok = Reserve && !(ZERO_REG != 0 && ReserveReg == '0);

   // Reservation is applied after the write clear so a same-register pair stays pending.
   always_comb begin
      pend_nx = pend;
      if (wr_ok) pend_nx[WriteReg] = 1'b0;
      if (rsv_ok) pend_nx[ReserveReg] = 1'b1;
      cnt_nx = '0;
      for (int i = 0; i < DEPTH; i++) cnt_nx = cnt_nx + (ADDR_W + 1)'(pend_nx[i]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         pend         <= '0;
         ResvConflict <= 1'b0;
         PendCount    <= '0;
      end else begin
         if (wr_ok) mem[WriteReg] <= WriteData;
         pend         <= pend_nx;
         ResvConflict <= rsv_ok && pend[ReserveReg];
         PendCount    <= cnt_nx;
      end
   end

   // Reads are gated by rst_n so a write presented during reset is never forwarded.
   always_comb begin
      z1        = ZERO_REG != 0 && ReadReg1 == '0;
      z2        = ZERO_REG != 0 && ReadReg2 == '0;
      byp1      = BYPASS != 0 && wr_ok && ReadReg1 == WriteReg;
      byp2      = BYPASS != 0 && wr_ok && ReadReg2 == WriteReg;
      ReadData1 = (!rst_n || z1) ? '0 : byp1 ? WriteData : mem[ReadReg1];
      ReadData2 = (!rst_n || z2) ? '0 : byp2 ? WriteData : mem[ReadReg2];
      Busy1     = rst_n && !z1 && !byp1 && pend[ReadReg1];
      Busy2     = rst_n && !z2 && !byp2 && pend[ReadReg2];
   end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed vector table plus reset/saturation sequences for reg_file_sb.
module tb_reg_file_sb;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        we = 1'b0;
   logic [4:0]  wa = '0;
   logic [31:0] wd = '0;
   logic [4:0]  ra1 = '0;
   logic [4:0]  ra2 = '0;
   logic        rs = 1'b0;
   logic [4:0]  rsa = '0;
   logic [31:0] rd1, rd2, nb_rd1, nb_rd2;
   logic        b1, b2, rc, nb_b1, nb_b2, nb_rc;
   logic [5:0]  pc, nb_pc;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   reg_file_sb dut (
      .clk(clk), .rst_n(rst_n), .RegWrite(we), .WriteReg(wa), .WriteData(wd),
      .ReadReg1(ra1), .ReadReg2(ra2), .ReadData1(rd1), .ReadData2(rd2),
      .Reserve(rs), .ReserveReg(rsa), .Busy1(b1), .Busy2(b2),
      .ResvConflict(rc), .PendCount(pc)
   );

   reg_file_sb #(.BYPASS(0)) nb (
      .clk(clk), .rst_n(rst_n), .RegWrite(we), .WriteReg(wa), .WriteData(wd),
      .ReadReg1(ra1), .ReadReg2(ra2), .ReadData1(nb_rd1), .ReadData2(nb_rd2),
      .Reserve(rs), .ReserveReg(rsa), .Busy1(nb_b1), .Busy2(nb_b2),
      .ResvConflict(nb_rc), .PendCount(nb_pc)
   );

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        rs;
      logic [4:0]  rsa;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic [31:0] d1;
      logic        b1;
      logic [31:0] d2;
      logic        b2;
      logic [31:0] n1;
      logic [5:0]  pc;
      logic        rc;
   } vec_t;

   vec_t v[16];

   function automatic vec_t mk(logic w, logic [4:0] a, logic [31:0] d, logic r, logic [4:0] ra,
                               logic [4:0] p1, logic [4:0] p2, logic [31:0] e1, logic eb1,
                               logic [31:0] e2, logic eb2, logic [31:0] en, logic [5:0] ep, logic er);
      vec_t x;
      x.we = w; x.wa = a; x.wd = d; x.rs = r; x.rsa = ra; x.r1 = p1; x.r2 = p2;
      x.d1 = e1; x.b1 = eb1; x.d2 = e2; x.b2 = eb2; x.n1 = en; x.pc = ep; x.rc = er;
      return x;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      we = 1'b0; rs = 1'b0; wa = '0; rsa = '0; wd = '0;
   endtask

   initial begin
      //          we wa  wd            rs rsa r1  r2  d1            b1 d2            b2 nb1           pc rc
      v[0]  = mk(0, 0,  0,            0, 0,  0,  31, 0,            0, 0,            0, 0,            0, 0);
      v[1]  = mk(1, 5,  32'hDEADBEEF, 0, 0,  5,  5,  32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0,            0, 0);
      v[2]  = mk(0, 0,  0,            1, 7,  5,  7,  32'hDEADBEEF, 0, 0,            0, 32'hDEADBEEF, 1, 0);
      v[3]  = mk(0, 0,  0,            0, 0,  5,  7,  32'hDEADBEEF, 0, 0,            1, 32'hDEADBEEF, 1, 0);
      v[4]  = mk(1, 7,  32'h12345678, 0, 0,  7,  7,  32'h12345678, 0, 32'h12345678, 0, 0,            0, 0);
      v[5]  = mk(0, 0,  0,            0, 0,  7,  7,  32'h12345678, 0, 32'h12345678, 0, 32'h12345678, 0, 0);
      v[6]  = mk(0, 0,  0,            1, 3,  3,  5,  0,            0, 32'hDEADBEEF, 0, 0,            1, 0);
      v[7]  = mk(0, 0,  0,            1, 3,  3,  5,  0,            1, 32'hDEADBEEF, 0, 0,            1, 1);
      v[8]  = mk(0, 0,  0,            0, 0,  3,  5,  0,            1, 32'hDEADBEEF, 0, 0,            1, 0);
      v[9]  = mk(1, 9,  32'hA5A5A5A5, 1, 9,  9,  3,  32'hA5A5A5A5, 0, 0,            1, 0,            2, 0);
      v[10] = mk(0, 0,  0,            0, 0,  9,  9,  32'hA5A5A5A5, 1, 32'hA5A5A5A5, 1, 32'hA5A5A5A5, 2, 0);
      v[11] = mk(1, 0,  32'hFFFFFFFF, 1, 0,  0,  0,  0,            0, 0,            0, 0,            2, 0);
      v[12] = mk(0, 0,  0,            0, 0,  0,  9,  0,            0, 32'hA5A5A5A5, 1, 0,            2, 0);
      v[13] = mk(1, 3,  32'h00000011, 0, 0,  3,  9,  32'h00000011, 0, 32'hA5A5A5A5, 1, 0,            1, 0);
      v[14] = mk(1, 20, 32'h00002020, 0, 0,  20, 3,  32'h00002020, 0, 32'h00000011, 0, 0,            1, 0);
      v[15] = mk(0, 0,  0,            1, 0,  0,  20, 0,            0, 32'h00002020, 0, 0,            1, 0);

      // Write and reserve while in reset must be ignored and outputs held at zero.
      we = 1'b1; wa = 5; wd = 32'hCAFEF00D; rs = 1'b1; rsa = 6; ra1 = 5; ra2 = 6;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rd1", rd1, 0);
      chk("rst_b1", 32'(b1), 0);
      chk("rst_b2", 32'(b2), 0);
      chk("rst_pc", 32'(pc), 0);
      chk("rst_rc", 32'(rc), 0);
      @(negedge clk);
      idle();
      rst_n = 1'b1;
      for (int i = 0; i < 32; i++) begin
         ra1 = 5'(i); ra2 = 5'(31 - i);
         #1;
         chk("init_rd1", rd1, 0);
         chk("init_rd2", rd2, 0);
         chk("init_busy", 32'({b1, b2}), 0);
      end
      chk("init_pc", 32'(pc), 0);

      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         we = v[i].we; wa = v[i].wa; wd = v[i].wd; rs = v[i].rs; rsa = v[i].rsa;
         ra1 = v[i].r1; ra2 = v[i].r2;
         #1;
         chk($sformatf("v%0d_rd1", i), rd1, v[i].d1);
         chk($sformatf("v%0d_b1", i), 32'(b1), 32'(v[i].b1));
         chk($sformatf("v%0d_rd2", i), rd2, v[i].d2);
         chk($sformatf("v%0d_b2", i), 32'(b2), 32'(v[i].b2));
         chk($sformatf("v%0d_nb_rd1", i), nb_rd1, v[i].n1);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_pc", i), 32'(pc), 32'(v[i].pc));
         chk($sformatf("v%0d_rc", i), 32'(rc), 32'(v[i].rc));
      end

      // Fill every nonzero register, then try r0: count saturates at 31 with no conflict.
      for (int i = 1; i < 32; i++) begin
         @(negedge clk);
         we = 1'b0; rs = 1'b1; rsa = 5'(i);
      end
      @(negedge clk);
      rsa = 0; ra1 = 12; ra2 = 5;
      @(posedge clk);
      #1;
      chk("full_pc", 32'(pc), 31);
      chk("full_rc", 32'(rc), 0);
      chk("full_b1", 32'(b1), 1);
      chk("full_rd2", rd2, 32'hDEADBEEF);
      @(negedge clk);
      idle();
      #2 rst_n = 1'b0;
      #1;
      chk("async_pc", 32'(pc), 0);
      chk("async_rd2", rd2, 0);
      chk("async_b1", 32'(b1), 0);
      chk("async_rc", 32'(rc), 0);
      @(negedge clk);
      rst_n = 1'b1;
      we = 1'b1; wa = 4; wd = 32'h00000044; ra1 = 4; ra2 = 12;
      #1;
      chk("post_nb_old", nb_rd1, 0);
      @(negedge clk);
      idle();
      #1;
      chk("post_rd1", rd1, 32'h00000044);
      chk("post_nb_rd1", nb_rd1, 32'h00000044);
      chk("post_b2", 32'(b2), 0);
      chk("post_pc", 32'(pc), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
